// File: rtl/joybus_if.sv
// Joybus responder signal bundle: line level in, drive-low out, payload and status.
// The master modport is the host/environment side; slave is the responder.
interface joybus_if;
  logic        jb_in;
  logic [31:0] btn_data;
  logic        jb_drive_low;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        busy;
  logic        rx_err;

  modport master (
    output jb_in, btn_data,
    input  jb_drive_low, cmd_valid, cmd_byte, busy, rx_err
  );

  modport slave (
    input  jb_in, btn_data,
    output jb_drive_low, cmd_valid, cmd_byte, busy, rx_err
  );
endinterface

// File: rtl/joybus_device.sv
// Joybus controller emulator: decodes one host command byte, replies with status or buttons.
// Define JB_RESET_CMD_EN to also answer command 0xFF with the 0x00 status reply.
module joybus_device #(
  parameter int US_CYCLES     = 25,
  parameter int RESP_DELAY_US = 2,
  parameter int TIMEOUT_US    = 8
) (
  input  logic clk,
  input  logic rst_n,
  joybus_if.slave jb
);

  localparam int TIMEOUT_CYC = TIMEOUT_US * US_CYCLES;
  localparam int RESP_CYC    = RESP_DELAY_US * US_CYCLES;
  localparam int BIT_CYC     = 4 * US_CYCLES;
  localparam int MAX_CYC     = (TIMEOUT_CYC > BIT_CYC) ?
                               ((TIMEOUT_CYC > RESP_CYC) ? TIMEOUT_CYC : RESP_CYC) :
                               ((BIT_CYC > RESP_CYC) ? BIT_CYC : RESP_CYC);
  localparam int CW          = $clog2(MAX_CYC + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t TIMEOUT_C  = cnt_t'(TIMEOUT_CYC);
  localparam cnt_t SAMPLE_C   = cnt_t'(2 * US_CYCLES);
  localparam cnt_t ONE_US_C   = cnt_t'(US_CYCLES);
  localparam cnt_t THREE_US_C = cnt_t'(3 * US_CYCLES);
  localparam cnt_t STOP_C     = cnt_t'(2 * US_CYCLES);
  localparam cnt_t BIT_END_C  = cnt_t'(BIT_CYC - 1);
  // Synchroniser, run counter and output flop add 3 cycles; trim so the wire gap is exact.
  localparam cnt_t RESP_T_C   = cnt_t'(RESP_CYC - 3);
  localparam cnt_t MAX_C      = '1;

`ifdef JB_RESET_CMD_EN
  localparam bit RESET_CMD_EN = 1'b1;
`else
  localparam bit RESET_CMD_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, RX_BIT, RX_HIGH, RX_STOP, RESP_WAIT, TX, TX_STOP, GUARD, DRAIN
  } state_t;

  state_t      state, state_n;
  cnt_t        cnt, cnt_n;
  cnt_t        hi_cnt, lo_cnt;
  logic [1:0]  sync;
  logic        line_prev;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  rx_sr, rx_sr_n;
  logic [31:0] tx_sr, tx_sr_n;
  logic [5:0]  tx_left, tx_left_n;
  logic [7:0]  cmd_q, cmd_n;
  logic        drive_q, drive_n;
  logic        cmd_valid_q, cmd_valid_n;
  logic        rx_err_q, rx_err_n;

  wire line = sync[1];
  wire fall = line_prev & ~line;

  function automatic logic is_supported(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'h01) || (RESET_CMD_EN && (b == 8'hFF));
  endfunction

  // Line synchroniser plus saturating run-length counters of the current line level.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is simply the highest-priority term of the D logic.
    if (!rst_n) begin
      sync      <= 2'b11;
      line_prev <= 1'b1;
      hi_cnt    <= '0;
      lo_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      sync      <= {sync[0], jb.jb_in};
      line_prev <= line;
      hi_cnt    <= !line ? '0 : ((hi_cnt != MAX_C) ? hi_cnt + 1'b1 : hi_cnt);
      lo_cnt    <=  line ? '0 : ((lo_cnt != MAX_C) ? lo_cnt + 1'b1 : lo_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      tx_left     <= '0;
      cmd_q       <= '0;
      drive_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_cnt_n;
      rx_sr       <= rx_sr_n;
      tx_sr       <= tx_sr_n;
      tx_left     <= tx_left_n;
      cmd_q       <= cmd_n;
      drive_q     <= drive_n;
      cmd_valid_q <= cmd_valid_n;
      rx_err_q    <= rx_err_n;
    end
  end

  always_comb begin
    // NOTE: every next-value defaults first, so no path through the case can infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    bit_cnt_n   = bit_cnt;
    rx_sr_n     = rx_sr;
    tx_sr_n     = tx_sr;
    tx_left_n   = tx_left;
    cmd_n       = cmd_q;
    drive_n     = 1'b0;
    cmd_valid_n = 1'b0;
    rx_err_n    = 1'b0;

    case (state)
      IDLE: if (fall) begin
        state_n   = RX_BIT;
        cnt_n     = cnt_t'(1);
        bit_cnt_n = '0;
      end
      RX_BIT: begin
        if (lo_cnt >= TIMEOUT_C) begin
          rx_err_n = 1'b1;
          state_n  = DRAIN;
        end else if (cnt == SAMPLE_C) begin
          rx_sr_n   = {rx_sr[6:0], line};
          bit_cnt_n = bit_cnt + 1'b1;
          state_n   = RX_HIGH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_HIGH: begin
        // A long high run means the host gave up and the bus is already idle.
        if (hi_cnt >= TIMEOUT_C) begin
          rx_err_n = 1'b1;
          state_n  = IDLE;
        end else if (fall) begin
          cnt_n   = cnt_t'(1);
          state_n = (bit_cnt == 4'd8) ? RX_STOP : RX_BIT;
        end
      end
      RX_STOP: begin
        if (lo_cnt >= TIMEOUT_C) begin
          rx_err_n = 1'b1;
          state_n  = DRAIN;
        end else if (line) begin
          if (is_supported(rx_sr)) begin
            cmd_n       = rx_sr;
            cmd_valid_n = 1'b1;
            tx_sr_n     = (rx_sr == 8'h01) ? jb.btn_data : {24'h05_00_02, 8'h00};
            tx_left_n   = (rx_sr == 8'h01) ? 6'd32 : 6'd24;
            state_n     = RESP_WAIT;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      RESP_WAIT: if (hi_cnt >= RESP_T_C) begin
        state_n = TX;
        cnt_n   = '0;
      end
      TX: begin
        drive_n = (cnt < (tx_sr[31] ? ONE_US_C : THREE_US_C));
        if (cnt == BIT_END_C) begin
          cnt_n     = '0;
          tx_sr_n   = {tx_sr[30:0], 1'b0};
          tx_left_n = tx_left - 1'b1;
          if (tx_left == 6'd1) state_n = TX_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_STOP: begin
        drive_n = 1'b1;
        if (cnt == STOP_C - 1'b1) state_n = GUARD;
        else                      cnt_n   = cnt + 1'b1;
      end
      GUARD:   if (hi_cnt >= ONE_US_C)  state_n = IDLE;
      DRAIN:   if (hi_cnt >= TIMEOUT_C) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign jb.jb_drive_low = drive_q;
  assign jb.cmd_valid    = cmd_valid_q;
  assign jb.cmd_byte     = cmd_q;
  assign jb.rx_err       = rx_err_q;
  assign jb.busy         = (state != IDLE);

endmodule
